// File: rtl/sqrt_nonrestoring_param_pkg.sv
// sqrt_nonrestoring_param_pkg: shared widths, FSM states and helpers for the sqrt engine
package sqrt_nonrestoring_param_pkg;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    function automatic int clog2(input int v);
        int n = 0;
        while ((1 << n) < v) n++;
        return n;
    endfunction

    function automatic int root_w(input int w);
        return w / 2;
    endfunction

    function automatic int rem_w(input int w);
        return w / 2 + 1;
    endfunction

    function automatic int cnt_w(input int w);
        return clog2(w / 2);
    endfunction

    function automatic bit width_ok(input int w);
        return (w % 2 == 0) && (w >= 4);
    endfunction

endpackage

// File: rtl/addsub_n.sv
// addsub_n: N-bit two's-complement add/subtract built from generate/propagate terms
module addsub_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    logic [N-1:0] bx, g, p;

    // subtract = invert b and inject carry-in 1; carries follow g | p & c
    always_comb begin
        logic cy;
        bx = b ^ {N{sub}};
        g = a & bx;
        p = a ^ bx;
        cy = sub;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = p[i] ^ cy;
            cy = g[i] | (p[i] & cy);
        end
    end

endmodule

// File: rtl/sqrt_nonrestoring_param.sv
// sqrt_nonrestoring_param: multi-cycle non-restoring integer square root, one root bit per clock
module sqrt_nonrestoring_param
    import sqrt_nonrestoring_param_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int QW = root_w(WIDTH),
    localparam int RW = rem_w(WIDTH),
    localparam int CW = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             round_en,
    input  logic             abort,
    output logic [QW-1:0]    q,
    output logic [RW-1:0]    r,
    output logic             rounded_up,
    output logic             busy,
    output logic             ready,
    output logic             done
);

    localparam int AW = RW + 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $fatal(1, "sqrt_nonrestoring_param: WIDTH must be even and >= 4");
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] d_reg;
    logic             rnd, r_neg;
    logic [QW-1:0]    r_low, q_part, q_nx;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    t, b, sum;
    logic [RW-1:0]    r_corr;
    logic             accept, kill, last, round_up;

    assign busy = (state == S_BUSY);

    // handshake decode and next-state; abort only bites while busy
    always_comb begin
        accept   = start && state == S_IDLE;
        kill     = abort && state == S_BUSY;
        last     = state == S_BUSY && !abort && cnt == CW'(QW - 1);
        state_nx = accept ? S_BUSY : (kill || last) ? S_IDLE : state;
        t        = {r_low, d_reg[WIDTH-1 -: 2]};
        b        = {q_part, r_neg, 1'b1};
    end

    // subtract while the partial remainder is non-negative, add otherwise
    addsub_n #(.N(AW)) u_addsub (
        .a   (t),
        .b   (b),
        .sub (!r_neg),
        .sum (sum)
    );

    // next root bit, remainder correction and round-to-nearest with saturation
    always_comb begin
        q_nx     = {q_part[QW-2:0], ~sum[AW-1]};
        r_corr   = sum[AW-1] ? sum[RW-1:0] + {q_nx, 1'b1} : sum[RW-1:0];
        round_up = rnd && (r_corr > RW'(q_nx)) && !(&q_nx);
    end

    // state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nx;
    end

    // datapath: load on accept, iterate while busy, publish result on the last step
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            d_reg      <= '0;
            rnd        <= 1'b0;
            r_neg      <= 1'b0;
            r_low      <= '0;
            q_part     <= '0;
            cnt        <= '0;
            q          <= '0;
            r          <= '0;
            rounded_up <= 1'b0;
            ready      <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                d_reg      <= d;
                rnd        <= round_en;
                r_neg      <= 1'b0;
                r_low      <= '0;
                q_part     <= '0;
                cnt        <= '0;
                q          <= '0;
                r          <= '0;
                rounded_up <= 1'b0;
                ready      <= 1'b0;
            end else if (kill) begin
                q          <= '0;
                r          <= '0;
                rounded_up <= 1'b0;
                ready      <= 1'b0;
            end else if (busy) begin
                d_reg  <= d_reg << 2;
                r_neg  <= sum[AW-1];
                r_low  <= sum[QW-1:0];
                q_part <= q_nx;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    q          <= q_nx + QW'(round_up);
                    r          <= r_corr;
                    rounded_up <= round_up;
                    ready      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sqrt_nonrestoring_param.md
Name: sqrt_nonrestoring_param

Overview:
Parametrised multi-cycle integer square root using the non-restoring algorithm. It computes q = floor(sqrt(d)) and r = d - q^2 for an unsigned radicand of WIDTH bits, at one result bit per clock.
New relative to the fixed 32-bit unit:
- width parameter
- optional round-to-nearest mode chosen per operation
- abort input
- single-cycle done pulse
- start ignored while busy
It serves as the shared sqrt engine for the arithmetic datapath blocks.

Parameters:
WIDTH, 32, radicand width; must be even and >= 4. QW = WIDTH/2 (root width), RW = QW+1 (remainder width), CW = clog2(QW) (counter width).

Ports:
clk  in  1  rising-edge clock
clr  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; accepted only when busy=0
d  in  WIDTH  radicand, sampled on accepted start
round_en  in  1  sampled on accepted start; 1 = round q to nearest
abort  in  1  cancels an operation in flight
q  out  QW  root (truncated, or rounded when round_en was set)
r  out  RW  corrected remainder d - q_trunc^2, always relative to the truncated root
rounded_up  out  1  1 when q was incremented by rounding
busy  out  1  operation in progress
ready  out  1  result valid; level signal
done  out  1  one-cycle pulse when the result becomes valid

Behaviour:
- Reset (clr=1, asynchronous):
  - busy=0, ready=0, done=0, rounded_up=0.
  - Internal d, q, r registers and the counter are cleared, so q=0 and r=0.
  - clr asserted mid-operation kills the operation; no done is produced.
- Accepted start (start=1 and busy=0):
  - Load d and round_en.
  - Clear the partial root, the signed partial remainder (RW+1 bits) and the counter.
  - busy<=1, ready<=0.
- start while busy=1 is ignored and does not disturb the operation in progress.
- Iteration (each cycle while busy and abort=0):
  - Let t = {r_part[RW-2:0], d_top2}.
  - If r_part >= 0: r_part <= t - {q_part, 2'b01}. Otherwise: r_part <= t + {q_part, 2'b11}.
  - q_part <= {q_part, ~sign(new r_part)}.
  - d shifts left by 2; the counter increments.
- Completion: on the iteration where count == QW-1:
  - busy<=0, ready<=1, done<=1 for exactly one cycle.
  - Latency is exactly QW cycles from the start edge to the ready edge (16 at the default width).
- Remainder correction, applied combinationally or registered at completion:
  - If r_part < 0, r = r_part + {q_part, 1}; otherwise r = r_part.
  - The result satisfies 0 <= r <= 2*q.
- Rounding (round_en latched = 1):
  - If r > q_trunc, then q = q_trunc+1 and rounded_up=1.
  - Saturation: if q_trunc is all ones, q stays all ones and rounded_up=0. No wrap is permitted.
  - Ties cannot occur for integer inputs.
- ready and the outputs hold until the next accepted start, abort or clr.
- Abort:
  - abort=1 while busy: busy<=0, ready<=0, no done, q/r/rounded_up cleared to 0 next cycle.
  - abort when not busy has no effect.
  - abort and start in the same cycle: abort wins if busy; if idle, start is accepted (abort is ignored).
- start in the same cycle as done: accepted, since busy has already dropped. The new operation begins and ready falls.
- Arithmetic:
  - The add/sub unit is RW+1 bits wide (QW+2), two's-complement.
  - Subtraction is done by XOR-inverting the operand with carry-in 1.
  - The counter wraps only through reload.

Decomposition:
- Shared arithmetic package holds:
  - clog2 constant function
  - derived widths QW, RW, CW as localparam expressions
  - a parameter legality check (WIDTH even, >= 4) that stops elaboration on violation
- Sub-module addsub_n (parametrised N-bit carry-lookahead add/subtract: a, b, sub, sum). It replaces the fixed 16-bit adder and is reusable by the divider blocks.

Test Plan:
- WIDTH=32, d=1000000, round_en=0 -> q=1000, r=0, rounded_up=0; ready exactly 16 cycles after start; done high for one cycle.
- WIDTH=32, d=999999, round_en=1 -> q=1000, r=1998, rounded_up=1. Same input with round_en=0 -> q=999, r=1998.
- WIDTH=32, d=0xFFFFFFFF, round_en=1 -> q=65535, r=131070, rounded_up=0 (saturation). d=0 -> q=0, r=0.
- WIDTH=8, d=17 -> q=4, r=1, latency 4 cycles. Exhaustively sweep d=0..255 with both round_en values against a reference model.
- start at cycle 0 (d=50); second start at cycle 3 with d=99 -> ignored, result q=7, r=1. Abort at cycle 5 of a new op -> busy falls next cycle, no done, ready=0, q=0.
- Assert clr mid-operation (cycle 7) -> outputs reset immediately. After release, start with d=144 -> q=12, r=0 with normal latency.
